// File: rtl/spi_tx_frame_buffer.sv
// SPI mode-0 frame transmitter: captures NBYTES bytes on load and shifts them
// out MSB-first under an active-high chip select, then pulses done.
module spi_tx_frame_buffer #(
  parameter int DSIZE   = 8,
  parameter int NBYTES  = 15,
  parameter int CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DSIZE*NBYTES-1:0] data_in,
  input  logic                    load,
  output logic                    busy,
  output logic                    spi_cs,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  output logic                    done,
  output logic                    ovr,
  output logic [1:0]              dbg_state
);

  localparam int PTR_W = 4;
  localparam int BIT_W = $clog2(DSIZE);
  localparam logic [7:0]       DIV_M1    = 8'(CLK_DIV - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NBYTES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DSIZE - 1);
  localparam logic [BIT_W-1:0] MSB_M1    = BIT_W'(DSIZE - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [DSIZE-1:0] frame_buf [NBYTES];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [BIT_W-1:0] bit_idx;
  logic [BIT_W-1:0] next_bit_sel;
  logic [7:0]       half_cnt;
  logic             last_bit;

  assign dbg_state    = state;
  assign next_ptr     = rd_ptr + PTR_W'(1);
  assign next_bit_sel = MSB_M1 - bit_idx;

  // Buffer is captured only on the accepting edge and is never reset.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && load) begin
      for (int k = 0; k < NBYTES; k++) begin
        frame_buf[k] <= data_in[k*DSIZE +: DSIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      spi_cs   <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      rd_ptr   <= '0;
      bit_idx  <= '0;
      half_cnt <= '0;
      last_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && busy) begin
        ovr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (load) begin
            state    <= SETUP;
            busy     <= 1'b1;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= data_in[DSIZE-1];
            ovr      <= 1'b0;
            rd_ptr   <= '0;
            bit_idx  <= '0;
            half_cnt <= DIV_M1;
            last_bit <= 1'b0;
          end
        end
        SETUP: begin
          if (half_cnt == 8'd0) begin
            spi_sclk <= 1'b1;
            half_cnt <= DIV_M1;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (half_cnt != 8'd0) begin
            half_cnt <= half_cnt - 8'd1;
          end else begin
            half_cnt <= DIV_M1;
            if (spi_sclk) begin
              // Falling edge: advance to the next bit, crossing bytes without a gap.
              spi_sclk <= 1'b0;
              if (bit_idx == LAST_BIT) begin
                bit_idx <= '0;
                if (rd_ptr == LAST_PTR) begin
                  last_bit <= 1'b1;
                  spi_mosi <= 1'b0;
                end else begin
                  rd_ptr   <= next_ptr;
                  spi_mosi <= frame_buf[next_ptr][DSIZE-1];
                end
              end else begin
                bit_idx  <= bit_idx + BIT_W'(1);
                spi_mosi <= frame_buf[rd_ptr][next_bit_sel];
              end
            end else if (last_bit) begin
              // The low half-period after the final fall has elapsed.
              state <= HOLD;
            end else begin
              spi_sclk <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (half_cnt == 8'd0) begin
            state  <= IDLE;
            spi_cs <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_frame_buffer.sv
// Bench for spi_tx_frame_buffer: three instances (CLK_DIV 2, 1, 255) driven by
// directed steps with random frames, checked against a bit-level frame model.
module tb_spi_tx_frame_buffer;

  localparam int W = 120;

  logic          clk;
  logic          rst_v   [3];
  logic          load_v  [3];
  logic [W-1:0]  data_v  [3];
  logic [2:0]    busy_v, cs_v, sclk_v, mosi_v, done_v, ovr_v;
  logic [1:0]    st_v    [3];

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];

  spi_tx_frame_buffer #(.DSIZE(8), .NBYTES(15), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst_v[0]), .data_in(data_v[0]), .load(load_v[0]),
    .busy(busy_v[0]), .spi_cs(cs_v[0]), .spi_sclk(sclk_v[0]), .spi_mosi(mosi_v[0]),
    .done(done_v[0]), .ovr(ovr_v[0]), .dbg_state(st_v[0]));

  spi_tx_frame_buffer #(.DSIZE(8), .NBYTES(15), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .data_in(data_v[1]), .load(load_v[1]),
    .busy(busy_v[1]), .spi_cs(cs_v[1]), .spi_sclk(sclk_v[1]), .spi_mosi(mosi_v[1]),
    .done(done_v[1]), .ovr(ovr_v[1]), .dbg_state(st_v[1]));

  spi_tx_frame_buffer #(.DSIZE(8), .NBYTES(15), .CLK_DIV(255)) dut2 (
    .clk(clk), .rst(rst_v[2]), .data_in(data_v[2]), .load(load_v[2]),
    .busy(busy_v[2]), .spi_cs(cs_v[2]), .spi_sclk(sclk_v[2]), .spi_mosi(mosi_v[2]),
    .done(done_v[2]), .ovr(ovr_v[2]), .dbg_state(st_v[2]));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (negedge sampling) ----------------
  int   cyc = 0;
  logic [2:0] p_sclk = '0, p_cs = '0, p_mosi = '0;
  logic rx_bits [3][0:255];
  int   rx_n [3];
  int   cs_rise_cyc [3], cs_fall_cyc [3], last_gap [3];
  int   done_cyc [3], done_period [3], done_cnt [3];
  int   hold_run [3], hold_len [3];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (cs_v[i] === 1'b1 && p_cs[i] === 1'b0) begin
        last_gap[i]    = cyc - cs_fall_cyc[i];
        cs_rise_cyc[i] = cyc;
        rx_n[i]        = 0;
        hold_run[i]    = 0;
      end
      if (cs_v[i] === 1'b0 && p_cs[i] === 1'b1) cs_fall_cyc[i] = cyc;
      if (sclk_v[i] === 1'b1 && p_sclk[i] === 1'b0) begin
        if (rx_n[i] < 256) rx_bits[i][rx_n[i]] = mosi_v[i];
        rx_n[i]++;
        check("mosi_stable_across_rise", 128'(mosi_v[i]), 128'(p_mosi[i]));
      end
      if (cs_v[i] === 1'b1 && p_cs[i] === 1'b1 && mosi_v[i] !== p_mosi[i])
        check("mosi_change_on_fall", 128'({p_sclk[i], sclk_v[i]}), 128'(2'b10));
      if (st_v[i] === 2'd3) hold_run[i]++;
      if (done_v[i] === 1'b1) begin
        done_period[i] = cyc - done_cyc[i];
        done_cyc[i]    = cyc;
        done_cnt[i]++;
        hold_len[i]    = hold_run[i];
      end
    end
    p_sclk = sclk_v;
    p_cs   = cs_v;
    p_mosi = mosi_v;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    #5;
  endtask

  function automatic logic [W-1:0] rand_frame();
    return W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic start_frame(input int idx, input logic [W-1:0] data);
    for (int k = 0; k < 15; k++) exp_q.push_back(data[k*8 +: 8]);
    data_v[idx] = data;
    load_v[idx] = 1'b1;
    tick();
    load_v[idx] = 1'b0;
    data_v[idx] = rand_frame();
    check("accept_cs", 128'(cs_v[idx]), 128'(1));
    check("accept_busy", 128'(busy_v[idx]), 128'(1));
    check("setup_sclk_low", 128'(sclk_v[idx]), 128'(0));
    check("setup_first_mosi", 128'(mosi_v[idx]), 128'(data[7]));
  endtask

  task automatic wait_done(input int idx, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_v[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_within_budget", 128'(ok), 128'(1));
  endtask

  // Compares the captured MOSI stream (one bit per sclk rise) against the queued bytes.
  task automatic check_frame(input int idx, input int exp_lat);
    logic [7:0] got, want;
    settle();
    check("rise_count", 128'(rx_n[idx]), 128'(120));
    for (int k = 0; k < 15; k++) begin
      got = '0;
      for (int b = 0; b < 8; b++) got = {got[6:0], rx_bits[idx][k*8+b]};
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("frame_byte", 128'(got), 128'(want));
    end
    check("done_latency", 128'(done_cyc[idx] - cs_rise_cyc[idx]), 128'(exp_lat));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] fa, fb, fc;
    int           dc, ones;

    for (int i = 0; i < 3; i++) begin
      rst_v[i]  = 1'b1;
      load_v[i] = 1'b1;
      data_v[i] = rand_frame();
    end

    // Reset with load asserted
    tick(2);
    for (int i = 0; i < 3; i++)
      check("reset_outputs",
            128'({busy_v[i], cs_v[i], sclk_v[i], mosi_v[i], done_v[i], ovr_v[i]}), 128'(0));
    for (int i = 0; i < 3; i++) begin
      rst_v[i]  = 1'b0;
      load_v[i] = 1'b0;
    end
    tick(3);
    check("no_frame_after_reset", 128'(cs_v), 128'(0));

    // Basic frame, bytes 0x01..0x0F
    fa = '0;
    for (int k = 0; k < 15; k++) fa[k*8 +: 8] = 8'(k + 1);
    start_frame(0, fa);
    wait_done(0, 600);
    check("done_cycle_cs_low", 128'({cs_v[0], busy_v[0]}), 128'(0));
    check_frame(0, 242 * 2);
    tick();
    check("done_single_cycle", 128'(done_v[0]), 128'(0));
    check("basic_ovr_clear", 128'(ovr_v[0]), 128'(0));

    // Overrun: a second load mid-frame must not disturb the frame
    tick($urandom_range(1, 5));
    fa = rand_frame();
    start_frame(0, fa);
    tick($urandom_range(50, 300));
    data_v[0] = rand_frame();
    load_v[0] = 1'b1;
    tick();
    load_v[0] = 1'b0;
    check("ovr_set", 128'(ovr_v[0]), 128'(1));
    wait_done(0, 600);
    check_frame(0, 242 * 2);
    tick(3);
    check("ovr_sticky", 128'(ovr_v[0]), 128'(1));
    fc = rand_frame();
    start_frame(0, fc);
    check("ovr_cleared_on_accept", 128'(ovr_v[0]), 128'(0));
    wait_done(0, 600);
    check_frame(0, 242 * 2);

    // Reset during byte 5, then a clean frame
    tick(2);
    fa = rand_frame();
    start_frame(0, fa);
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (rx_n[0] >= 43) break;
    end
    check("reached_byte5", 128'(rx_n[0] >= 43), 128'(1));
    dc = done_cnt[0];
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("abort_outputs", 128'({cs_v[0], sclk_v[0], busy_v[0], mosi_v[0]}), 128'(0));
    exp_q.delete();
    tick(600);
    check("abort_no_done", 128'(done_cnt[0]), 128'(dc));
    fb = rand_frame();
    start_frame(0, fb);
    wait_done(0, 600);
    check_frame(0, 242 * 2);

    // A few random frames with random gaps
    for (int r = 0; r < 3; r++) begin
      tick($urandom_range(1, 20));
      start_frame(0, rand_frame());
      wait_done(0, 600);
      check_frame(0, 242 * 2);
    end

    // Back-to-back with load held, CLK_DIV=1, all bytes 0xA5
    data_v[1] = {15{8'hA5}};
    load_v[1] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 15; k++) exp_q.push_back(8'hA5);
      wait_done(1, 300);
      if (f == 2) load_v[1] = 1'b0;
      check_frame(1, 242);
      if (f > 0) begin
        check("b2b_done_period", 128'(done_period[1]), 128'(243));
        check("b2b_cs_gap", 128'(last_gap[1]), 128'(1));
      end
    end
    tick(3);
    check("b2b_stops", 128'(cs_v[1]), 128'(0));
    check("b2b_ovr_seen", 128'(ovr_v[1]), 128'(1));

    // Boundary: CLK_DIV=255, only byte14 bit7 set
    fa = '0;
    fa[119] = 1'b1;
    start_frame(2, fa);
    wait_done(2, 62000);
    check_frame(2, 242 * 255);
    ones = 0;
    for (int b = 0; b < 120; b++) if (rx_bits[2][b] === 1'b1) ones++;
    check("boundary_single_high", 128'(ones), 128'(1));
    check("boundary_rise113_high", 128'(rx_bits[2][112]), 128'(1));
    check("boundary_hold_len", 128'(hold_len[2]), 128'(255));
    tick();
    check("boundary_idle", 128'({cs_v[2], busy_v[2], done_v[2]}), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
